serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor with borrow-in and borrow-out. It computes {Bo, Diff} = A − B − Bi over WIDTH clock cycles, one bit per cycle, LSB first. It is the sequential counterpart to the team's combinational adder blocks and trades area for latency in the add/subtract datapath library. Operands enter through a valid/ready handshake and the result leaves through another, so the block drops between pipeline stages that apply backpressure.

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/full_sub_cell.sv | 19 +
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the add/subtract datapath library.
//   state_t        - FSM states of the serial_subtractor (IDLE, RUN, HOLD)
//   ADDSUB_WIDTH   - default operand width shared with the combinational adders
//   sub_diff()     - difference bit of a one-bit full subtractor
//   sub_borrow()   - borrow-out of a one-bit full subtractor
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic sub_diff(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  // Borrow when b exceeds a outright, or a == b and a borrow is pending.
  function automatic logic sub_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: combinational one-bit full subtractor, computes a - b - br_in.
//   a, b    - operand bits
//   br_in   - borrow from the less significant bit
//   d       - difference bit
//   br_out  - borrow into the next more significant bit
module full_sub_cell
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = sub_diff(a, b, br_in);
  assign br_out = sub_borrow(a, b, br_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, {Bo, Diff} = A - B - Bi,
// one bit per cycle LSB first, WIDTH cycles from accept to result.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (in_ready high only in IDLE)
//   A, B, Bi            - minuend, subtrahend, borrow-in (sampled at accept)
//   out_valid, out_ready- result handshake (out_valid high only in HOLD)
//   Diff, Bo            - difference mod 2^WIDTH and borrow-out
//   dbg_state           - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid/ready are decoded from the state register only, so neither
// in_valid nor out_ready reaches in_ready/out_valid combinationally. While
// out_valid is high and out_ready low, Diff and Bo hold steady.
module serial_subtractor
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bo,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d, cell_br;
  logic             accept, consume, last_bit;

  full_sub_cell u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .br_in  (br),
    .d      (cell_d),
    .br_out (cell_br)
  );

  // in_ready is held low while reset is asserted even though state is IDLE.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == HOLD);
  assign Bo        = br;
  assign dbg_state = state;

  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = HOLD;
      HOLD:    if (consume)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr <= A;
            b_sr <= B;
            br   <= Bi;
            cnt  <= '0;
          end
        end
        RUN: begin
          // Result fills from the MSB end so it is LSB-aligned after WIDTH bits.
          Diff <= {cell_d, Diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= cell_br;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import addsub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       iv4, ir4, ov4, or4, bi4, bo4;
  logic [3:0] a4, b4, d4;
  state_t     st4;
  logic       iv8, ir8, ov8, or8, bi8, bo8;
  logic [7:0] a8, b8, d8;
  state_t     st8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .A(a4), .B(b4), .Bi(bi4), .out_valid(ov4), .out_ready(or4),
    .Diff(d4), .Bo(bo4), .dbg_state(st4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .Bi(bi8), .out_valid(ov8), .out_ready(or8),
    .Diff(d8), .Bo(bo8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {Bo, Diff} expected per operation
  bit sel8 = 1'b0;        // which DUT the tasks talk to

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the unsigned operands.
  function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bi);
    int r;
    int m;
    logic [8:0] res;
    r = a - b - bi;
    m = 1 << w;
    res = '0;
    res[7:0] = 8'(((r % m) + m) % m);
    res[8]   = (r < 0);
    return res;
  endfunction

  function automatic logic o_valid();  return sel8 ? ov8 : ov4; endfunction
  function automatic logic o_ready_in(); return sel8 ? ir8 : ir4; endfunction
  function automatic logic [7:0] o_diff(); return sel8 ? d8 : {4'b0, d4}; endfunction
  function automatic logic o_bo();     return sel8 ? bo8 : bo4; endfunction
  function automatic int   cur_w();    return sel8 ? 8 : 4; endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
    if (sel8) begin iv8 = v; a8 = a; b8 = b; bi8 = bi; end
    else begin iv4 = v; a4 = a[3:0]; b4 = b[3:0]; bi4 = bi; end
  endtask

  task automatic set_out_ready(input logic r);
    if (sel8) or8 = r; else or4 = r;
  endtask

  // Present operands at a negedge once in_ready is up, accept at next posedge,
  // then scramble the inputs so late changes would corrupt a non-sampling DUT.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int n = 0;
    @(negedge clk);
    while (!o_ready_in() && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", 32'(o_ready_in()), 32'd1);
    drive_in(1'b1, a, b, bi);
    exp_q.push_back(ref_sub(cur_w(), int'(a), int'(b), int'(bi)));
    @(posedge clk);
    #1;
    drive_in(1'b0, ~a, ~b, ~bi);
  endtask

  // Count edges after accept until out_valid, then compare against the queue.
  task automatic wait_result(input string tag);
    int lat = 0;
    logic [8:0] exp;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!o_valid() && lat < 4 * cur_w() + 10);
    check({tag, "_latency"}, 32'(lat), 32'(cur_w()));
    exp = exp_q.pop_front();
    check({tag, "_diff"}, 32'(o_diff()), 32'(exp[7:0]));
    check({tag, "_bo"}, 32'(o_bo()), 32'(exp[8]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] ra, rb;
    logic rbi;
    int n;
    iv4 = 0; a4 = 0; b4 = 0; bi4 = 0; or4 = 1;
    iv8 = 0; a8 = 0; b8 = 0; bi8 = 0; or8 = 1;

    // reset state
    #12;
    check("rst_in_ready_low", 32'(ir4), 32'd0);
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_diff", 32'(d4), 32'd0);
    check("rst_bo", 32'(bo4), 32'd0);
    check("rst_state", 32'(st4), 32'(IDLE));
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_in_ready_high", 32'(ir4), 32'd1);

    // 1: 0 - 1 - 1 = -2 -> 1110 borrow; out_valid for exactly one cycle
    sel8 = 0;
    start_op(8'h0, 8'h1, 1'b1);
    wait_result("t1");
    check("t1_diff_const", 32'(d4), 32'hE);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", 32'(ov4), 32'd0);
    check("t1_ready_after", 32'(ir4), 32'd1);

    // 2: in_valid during RUN is ignored
    start_op(8'hF, 8'h4, 1'b0);
    drive_in(1'b1, 8'h0, 8'h0, 1'b0);
    check("t2_ready_in_run", 32'(ir4), 32'd0);
    @(posedge clk); #1;
    check("t2_ready_in_run2", 32'(ir4), 32'd0);
    drive_in(1'b0, 8'h0, 8'h0, 1'b0);
    // Only 3 edges remain before the result; wait_result counts from accept.
    begin
      int lat = 1;
      logic [8:0] exp;
      do begin @(posedge clk); #1; lat++; end while (!ov4 && lat < 20);
      check("t2_latency", 32'(lat), 32'd4);
      exp = exp_q.pop_front();
      check("t2_diff", 32'(d4), 32'(exp[3:0]));
      check("t2_bo", 32'(bo4), 32'(exp[8]));
      check("t2_diff_const", 32'(d4), 32'hB);
    end
    @(posedge clk); #1;
    check("t2_no_extra_op", 32'(st4), 32'(IDLE));

    // 3: backpressure, result stable for 5 cycles
    @(negedge clk); set_out_ready(1'b0);
    start_op(8'h5, 8'h5, 1'b0);
    wait_result("t3");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(ov4), 32'd1);
      check("t3_hold_diff", 32'(d4), 32'h0);
      check("t3_hold_bo", 32'(bo4), 32'd0);
      check("t3_hold_in_ready", 32'(ir4), 32'd0);
    end
    @(negedge clk); set_out_ready(1'b1);
    @(posedge clk); #1;
    check("t3_ready_after_hs", 32'(ir4), 32'd1);
    check("t3_valid_after_hs", 32'(ov4), 32'd0);

    // 4: WIDTH=8 boundaries
    sel8 = 1;
    start_op(8'h00, 8'hFF, 1'b1);
    wait_result("t4a");
    check("t4a_diff_const", 32'(d8), 32'h00);
    check("t4a_bo_const", 32'(bo8), 32'd1);
    start_op(8'hC8, 8'h37, 1'b0);
    wait_result("t4b");
    check("t4b_diff_const", 32'(d8), 32'h91);

    // 5: reset mid-RUN discards the operation
    sel8 = 0;
    @(posedge clk);
    start_op(8'h8, 8'h1, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(ov4), 32'd0);
    check("t5_diff", 32'(d4), 32'h0);
    check("t5_bo", 32'(bo4), 32'd0);
    check("t5_in_ready_low", 32'(ir4), 32'd0);
    check("t5_state", 32'(st4), 32'(IDLE));
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (ov4) n++; end
    check("t5_no_output", 32'(n), 32'd0);
    start_op(8'h3, 8'h2, 1'b0);
    wait_result("t5_next");
    check("t5_next_const", 32'(d4), 32'h1);

    // 6: random back-to-back on both widths
    for (int w = 0; w < 2; w++) begin
      sel8 = (w == 1);
      for (int i = 0; i < 600; i++) begin
        ra  = 8'($urandom_range(0, 255));
        rb  = 8'($urandom_range(0, 255));
        rbi = 1'($urandom_range(0, 1));
        if (!sel8) begin ra[7:4] = 4'h0; rb[7:4] = 4'h0; end
        start_op(ra, rb, rbi);
        wait_result(sel8 ? "rnd8" : "rnd4");
      end
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
